// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch arbiter.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 64;
  localparam int unsigned INSTR_W      = 32;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_METAL_MASK = 64'h0000_0000_0000_ffff;

  typedef enum logic {
    CORE,
    METAL
  } fetch_owner_e;

  typedef enum logic {
    IDLE,
    ACCESS
  } arb_state_e;

endpackage

// File: rtl/fetch_prio_arb.sv
// Two-way fixed-priority pick favouring Metal, with a saturating starvation
// counter that forces a core grant after STARVE_LIMIT back-to-back Metal wins.
module fetch_prio_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,        // arbiter may grant this cycle
  input  logic core_elig,     // core valid and not flushed
  input  logic metal_elig,
  input  logic core_waiting,  // raw core valid, for starvation accounting
  output logic grant_core,
  output logic grant_metal
);

  // A zero limit still needs a 1-bit counter so the vector is legal.
  localparam int unsigned CntW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            limit_hit;

  assign limit_hit = (STARVE_LIMIT != 0) && (cnt_q == Limit);

  // Grant selection and next-state of the starvation counter.
  always_comb begin
    grant_metal = arb_en && metal_elig && !(core_elig && limit_hit);
    grant_core  = arb_en && core_elig && !grant_metal;
    cnt_d       = cnt_q;
    if (grant_core) begin
      cnt_d = '0;
    end else if (grant_metal) begin
      if (!core_waiting) begin
        cnt_d = '0;
      end else if (cnt_q != Limit) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/icache_fetch_arbiter.sv
// Shares the instruction-memory read port between core fetch and Metal fetch,
// sequences each access through the stall handshake and routes the word back.
module icache_fetch_arbiter
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W       = FETCH_ADDR_W,
  parameter int unsigned        DATA_W       = INSTR_W,
  parameter logic [ADDR_W-1:0]  METAL_MASK   = FETCH_METAL_MASK,
  parameter int unsigned        STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_resp_data,
  input  logic              metal_req_valid,
  output logic              metal_req_ready,
  input  logic [ADDR_W-1:0] metal_req_addr,
  output logic              metal_resp_valid,
  output logic [DATA_W-1:0] metal_resp_data,
  input  logic              core_flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_stall
);

  arb_state_e        state_q, state_d;
  fetch_owner_e      owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sup_q, sup_d;    // core response killed by a flush
  logic              core_rv_q, core_rv_d;
  logic              metal_rv_q, metal_rv_d;
  logic [DATA_W-1:0] core_rd_q, core_rd_d;
  logic [DATA_W-1:0] metal_rd_q, metal_rd_d;

  logic              arb_en, grant_core, grant_metal;
  logic [ADDR_W-1:0] metal_eff, core_eff;

  // Gating with reset_n keeps the readies low during the reset cycle.
  assign arb_en    = reset_n && (state_q == IDLE);
  assign metal_eff = {metal_req_addr[ADDR_W-1:2] & METAL_MASK[ADDR_W-1:2], 2'b00};
  assign core_eff  = {core_req_addr[ADDR_W-1:2], 2'b00};

  fetch_prio_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .arb_en      (arb_en),
    .core_elig   (core_req_valid && !core_flush),
    .metal_elig  (metal_req_valid),
    .core_waiting(core_req_valid),
    .grant_core  (grant_core),
    .grant_metal (grant_metal)
  );

  assign core_req_ready   = grant_core;
  assign metal_req_ready  = grant_metal;
  assign mem_read_en      = (state_q == ACCESS);
  assign mem_addr         = addr_q;
  assign core_resp_valid  = core_rv_q;
  assign core_resp_data   = core_rd_q;
  assign metal_resp_valid = metal_rv_q;
  assign metal_resp_data  = metal_rd_q;

  // Next-state: accept in IDLE, complete and route the word in ACCESS.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    sup_d      = sup_q;
    core_rv_d  = 1'b0;
    metal_rv_d = 1'b0;
    core_rd_d  = core_rd_q;
    metal_rd_d = metal_rd_q;
    case (state_q)
      IDLE: begin
        if (grant_metal) begin
          owner_d = METAL;
          addr_d  = metal_eff;
          sup_d   = 1'b0;
          state_d = ACCESS;
        end else if (grant_core) begin
          owner_d = CORE;
          addr_d  = core_eff;
          sup_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sup_d = sup_q || ((owner_q == CORE) && core_flush);
        if (!mem_stall) begin
          state_d = IDLE;
          sup_d   = 1'b0;
          if (owner_q == METAL) begin
            metal_rd_d = mem_data;
            metal_rv_d = 1'b1;
          end else if (!(sup_q || core_flush)) begin
            core_rd_d = mem_data;
            core_rv_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address latch and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= CORE;
      addr_q     <= '0;
      sup_q      <= 1'b0;
      core_rv_q  <= 1'b0;
      metal_rv_q <= 1'b0;
      core_rd_q  <= '0;
      metal_rd_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      sup_q      <= sup_d;
      core_rv_q  <= core_rv_d;
      metal_rv_q <= metal_rv_d;
      core_rd_q  <= core_rd_d;
      metal_rd_q <= metal_rd_d;
    end
  end

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// a negedge monitor pops and compares each response pulse.
module tb_icache_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req_valid, metal_req_valid, core_flush, mem_stall;
  logic [63:0] core_req_addr, metal_req_addr;
  logic [31:0] mem_data;

  logic        core_req_ready, metal_req_ready, core_resp_valid, metal_resp_valid;
  logic [31:0] core_resp_data, metal_resp_data;
  logic [63:0] mem_addr;
  logic        mem_read_en;

  // Strict-priority instance sharing the same stimulus.
  logic        core_req_ready_z, metal_req_ready_z, core_resp_valid_z, metal_resp_valid_z;
  logic [31:0] core_resp_data_z, metal_resp_data_z;
  logic [63:0] mem_addr_z;
  logic        mem_read_en_z;

  int checks = 0;
  int errors = 0;

  // {is_metal, data}
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  icache_fetch_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_resp_valid(core_resp_valid),
    .core_resp_data(core_resp_data),
    .metal_req_valid(metal_req_valid), .metal_req_ready(metal_req_ready),
    .metal_req_addr(metal_req_addr), .metal_resp_valid(metal_resp_valid),
    .metal_resp_data(metal_resp_data),
    .core_flush(core_flush), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_data(mem_data), .mem_stall(mem_stall)
  );

  icache_fetch_arbiter #(.STARVE_LIMIT(0)) dut_strict (
    .clk(clk), .reset_n(reset_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready_z),
    .core_req_addr(core_req_addr), .core_resp_valid(core_resp_valid_z),
    .core_resp_data(core_resp_data_z),
    .metal_req_valid(metal_req_valid), .metal_req_ready(metal_req_ready_z),
    .metal_req_addr(metal_req_addr), .metal_resp_valid(metal_resp_valid_z),
    .metal_resp_data(metal_resp_data_z),
    .core_flush(core_flush), .mem_addr(mem_addr_z), .mem_read_en(mem_read_en_z),
    .mem_data(mem_data), .mem_stall(mem_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      check("one_resp", 64'(core_resp_valid && metal_resp_valid), 64'd0);
      check("one_ready", 64'(core_req_ready && metal_req_ready), 64'd0);
      if (core_resp_valid || metal_resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {62'd0, metal_resp_valid, core_resp_valid}, 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("resp_owner", 64'(metal_resp_valid), 64'(e[32]));
          check("resp_data", 64'(metal_resp_valid ? metal_resp_data : core_resp_data),
                64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    logic [9:0] pattern;
    int         ngrant, z_core, z_metal;

    reset_n = 1'b0; core_req_valid = 1'b0; metal_req_valid = 1'b0;
    core_flush = 1'b0; mem_stall = 1'b0; mem_data = '0;
    core_req_addr = '0; metal_req_addr = '0;
    repeat (2) tick();
    core_req_valid = 1'b1; metal_req_valid = 1'b1;
    @(negedge clk);
    check("rst_core_ready", 64'(core_req_ready), 64'd0);
    check("rst_metal_ready", 64'(metal_req_ready), 64'd0);
    check("rst_read_en", 64'(mem_read_en), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_resp_data", {core_resp_data, metal_resp_data}, 64'd0);
    tick();
    core_req_valid = 1'b0; metal_req_valid = 1'b0; reset_n = 1'b1;
    tick();

    // Core-only fetch.
    core_req_valid = 1'b1; core_req_addr = 64'h1000; mem_data = 32'h0000_0013;
    @(negedge clk);
    check("t1_core_ready", 64'(core_req_ready), 64'd1);
    exp_q.push_back({1'b0, 32'h0000_0013});
    tick();
    core_req_valid = 1'b0;
    @(negedge clk);
    check("t1_read_en", 64'(mem_read_en), 64'd1);
    check("t1_mem_addr", mem_addr, 64'h1000);
    tick();
    @(negedge clk);
    check("t1_core_resp_valid", 64'(core_resp_valid), 64'd1);
    check("t1_metal_resp_valid", 64'(metal_resp_valid), 64'd0);
    tick();

    // Metal fetch with masking and low-bit clearing.
    metal_req_valid = 1'b1; metal_req_addr = 64'h8000_0000_0001_2346;
    mem_data = 32'hdead_beef;
    @(negedge clk);
    check("t2_metal_ready", 64'(metal_req_ready), 64'd1);
    exp_q.push_back({1'b1, 32'hdead_beef});
    tick();
    metal_req_valid = 1'b0;
    @(negedge clk);
    check("t2_mem_addr", mem_addr, 64'h2344);
    tick();
    @(negedge clk);
    check("t2_metal_resp_valid", 64'(metal_resp_valid), 64'd1);
    tick();

    // Both valid continuously: M,M,M,M,C,M,M,M,M,C.
    mem_data = 32'h0000_a0a0;
    core_req_addr = 64'h100; metal_req_addr = 64'h200;
    core_req_valid = 1'b1; metal_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back({(k != 4 && k != 9), 32'h0000_a0a0});
    end
    pattern = '0; ngrant = 0; z_core = 0; z_metal = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_req_ready || metal_req_ready) begin
        if (ngrant < 10) pattern[ngrant] = core_req_ready;
        ngrant++;
      end
      if (core_req_ready_z) z_core++;
      if (metal_req_ready_z) z_metal++;
      tick();
    end
    core_req_valid = 1'b0; metal_req_valid = 1'b0;
    check("t3_grant_count", 64'(ngrant), 64'd10);
    check("t3_grant_pattern", 64'(pattern), 64'(10'b10_0001_0000));
    check("t3_strict_core_grants", 64'(z_core), 64'd0);
    check("t3_strict_metal_grants", 64'(z_metal), 64'd10);
    repeat (2) tick();

    // Core access with three stall cycles.
    core_req_valid = 1'b1; core_req_addr = 64'h2000; mem_data = 32'h1234_5678;
    @(negedge clk);
    check("t4_core_ready", 64'(core_req_ready), 64'd1);
    exp_q.push_back({1'b0, 32'h1234_5678});
    tick();
    for (int j = 0; j < 4; j++) begin
      mem_stall       = (j < 3);
      core_req_valid  = (j < 3);
      metal_req_valid = (j < 3);
      @(negedge clk);
      check("t4_read_en", 64'(mem_read_en), 64'd1);
      check("t4_mem_addr", mem_addr, 64'h2000);
      check("t4_no_ready", 64'(core_req_ready || metal_req_ready), 64'd0);
      tick();
    end
    @(negedge clk);
    check("t4_core_resp_valid", 64'(core_resp_valid), 64'd1);
    tick();

    // Flush on the second stall cycle kills the core response.
    core_req_valid = 1'b1; core_req_addr = 64'h3000; mem_data = 32'h0000_9999;
    @(negedge clk);
    check("t5_core_ready", 64'(core_req_ready), 64'd1);
    tick();
    core_req_valid = 1'b0; mem_stall = 1'b1;
    tick();
    core_flush = 1'b1;
    tick();
    core_flush = 1'b0;
    tick();
    mem_stall = 1'b0;
    @(negedge clk);
    check("t5_read_en", 64'(mem_read_en), 64'd1);
    tick();
    metal_req_valid = 1'b1; metal_req_addr = 64'h40; mem_data = 32'h0000_0055;
    @(negedge clk);
    check("t5_core_resp_valid", 64'(core_resp_valid), 64'd0);
    check("t5_core_data_held", 64'(core_resp_data), 64'h1234_5678);
    check("t5_metal_ready", 64'(metal_req_ready), 64'd1);
    exp_q.push_back({1'b1, 32'h0000_0055});
    tick();
    metal_req_valid = 1'b0;
    @(negedge clk);
    check("t5_mem_addr", mem_addr, 64'h40);
    tick();
    @(negedge clk);
    check("t5_metal_resp_valid", 64'(metal_resp_valid), 64'd1);
    tick();

    // Reset mid-access abandons it.
    core_req_valid = 1'b1; core_req_addr = 64'h5000; mem_data = 32'h0000_aaaa;
    mem_stall = 1'b1;
    @(negedge clk);
    check("t6_core_ready", 64'(core_req_ready), 64'd1);
    tick();
    core_req_valid = 1'b0;
    @(negedge clk);
    check("t6_read_en", 64'(mem_read_en), 64'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_stall = 1'b0;
    @(negedge clk);
    check("t6_rst_read_en", 64'(mem_read_en), 64'd0);
    check("t6_rst_mem_addr", mem_addr, 64'd0);
    check("t6_rst_resp_valid", 64'(core_resp_valid || metal_resp_valid), 64'd0);
    check("t6_rst_resp_data", {core_resp_data, metal_resp_data}, 64'd0);
    tick();
    core_req_valid = 1'b1; core_req_addr = 64'h6000; mem_data = 32'h0000_0077;
    @(negedge clk);
    check("t6_core_ready2", 64'(core_req_ready), 64'd1);
    exp_q.push_back({1'b0, 32'h0000_0077});
    tick();
    core_req_valid = 1'b0;
    @(negedge clk);
    check("t6_mem_addr", mem_addr, 64'h6000);
    tick();
    @(negedge clk);
    check("t6_core_resp_valid", 64'(core_resp_valid), 64'd1);
    tick();

    repeat (3) tick();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
